// File: rtl/snake_pkg.sv
// Shared snake game types and playfield constants; also used by the food generator and the renderer.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam int SEGMENT_SIZE = 10;
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int COORD_W      = 10;

    // Each direction and its reverse differ only in the LSB (UP<->DOWN, LEFT<->RIGHT).
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running divider: o_moveTick is high for one clock out of every TICK_DIV clocks.
module move_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_moveTick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last     = (r_count == CNT_W'(TICK_DIV - 1));
    assign o_moveTick = w_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/snake_ctrl.sv
// Snake movement, growth and collision controller feeding the food generator and renderer.
// Define SNAKE_WRAP_EN to make the head wrap around the playfield edges instead of hitting walls.
module snake_ctrl #(
    parameter int SEGMENT_SIZE = snake_pkg::SEGMENT_SIZE,
    parameter int SCREEN_W     = snake_pkg::SCREEN_W,
    parameter int SCREEN_H     = snake_pkg::SCREEN_H,
    parameter int MAX_LEN      = 32,
    parameter int INIT_LEN     = 3,
    parameter int TICK_DIV     = 5000000,
    parameter int START_X      = 320,
    parameter int START_Y      = 240
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic [9:0]                   food_x,
    input  logic [9:0]                   food_y,
    input  logic [$clog2(MAX_LEN)-1:0]   seg_idx,
    output logic [9:0]                   seg_x,
    output logic [9:0]                   seg_y,
    output logic [9:0]                   head_x,
    output logic [9:0]                   head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         food_eaten,
    output logic                         game_over
);

    import snake_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [COORD_W-1:0] r_segX [MAX_LEN];
    logic [COORD_W-1:0] r_segY [MAX_LEN];
    logic [LEN_W-1:0]   r_length;
    dir_t               r_dir;
    dir_t               r_pending;
    state_t             r_state;
    logic               r_foodEaten;
    logic               r_gameOver;

    logic               w_moveTick;
    logic               w_btnValid;
    dir_t               w_btnDir;
    dir_t               w_dirEff;
    logic [COORD_W-1:0] w_nextX;
    logic [COORD_W-1:0] w_nextY;
    logic               w_wall;
    logic               w_eat;
    logic               w_self;
    logic               w_hit;
    logic [LEN_W-1:0]   w_limit;

    move_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk      (clk),
        .i_reset    (reset),
        .o_moveTick (w_moveTick)
    );

    assign seg_x      = r_segX[seg_idx];
    assign seg_y      = r_segY[seg_idx];
    assign head_x     = r_segX[0];
    assign head_y     = r_segY[0];
    assign length     = r_length;
    assign food_eaten = r_foodEaten;
    assign game_over  = r_gameOver;

    // In the step cycle the pending direction becomes dir, so reversal is judged against it.
    assign w_dirEff = w_moveTick ? r_pending : r_dir;

    always_comb begin
        w_btnValid = 1'b1;
        w_btnDir   = r_pending;
        if (btn_up)         w_btnDir = UP;
        else if (btn_down)  w_btnDir = DOWN;
        else if (btn_left)  w_btnDir = LEFT;
        else if (btn_right) w_btnDir = RIGHT;
        else                w_btnValid = 1'b0;
    end

    always_comb begin
        w_nextX = r_segX[0];
        w_nextY = r_segY[0];
        w_wall  = 1'b0;
        case (r_pending)
            UP: begin
                w_wall  = (r_segY[0] == '0);
                w_nextY = w_wall ? COORD_W'(SCREEN_H - SEGMENT_SIZE) : r_segY[0] - COORD_W'(SEGMENT_SIZE);
            end
            DOWN: begin
                w_wall  = (r_segY[0] == COORD_W'(SCREEN_H - SEGMENT_SIZE));
                w_nextY = w_wall ? '0 : r_segY[0] + COORD_W'(SEGMENT_SIZE);
            end
            LEFT: begin
                w_wall  = (r_segX[0] == '0);
                w_nextX = w_wall ? COORD_W'(SCREEN_W - SEGMENT_SIZE) : r_segX[0] - COORD_W'(SEGMENT_SIZE);
            end
            default: begin
                w_wall  = (r_segX[0] == COORD_W'(SCREEN_W - SEGMENT_SIZE));
                w_nextX = w_wall ? '0 : r_segX[0] + COORD_W'(SEGMENT_SIZE);
            end
        endcase
    end

    assign w_eat = (w_nextX == food_x) && (w_nextY == food_y);

    // The tail cell vacates on a plain move, but stays occupied when the snake grows.
    always_comb begin
        w_self  = 1'b0;
        w_limit = w_eat ? r_length : r_length - LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < w_limit) && (r_segX[i] == w_nextX) && (r_segY[i] == w_nextY)) begin
                w_self = 1'b1;
            end
        end
    end

`ifdef SNAKE_WRAP_EN
    assign w_hit = w_self;
`else
    assign w_hit = w_self | w_wall;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_segX[i] <= (i < INIT_LEN) ? COORD_W'(START_X - i * SEGMENT_SIZE) : COORD_W'(START_X);
                r_segY[i] <= COORD_W'(START_Y);
            end
            r_length    <= LEN_W'(INIT_LEN);
            r_dir       <= RIGHT;
            r_pending   <= RIGHT;
            r_state     <= PLAY;
            r_foodEaten <= 1'b0;
            r_gameOver  <= 1'b0;
        end else begin
            r_foodEaten <= 1'b0;
            case (r_state)
                PLAY: begin
                    if (w_btnValid && (w_btnDir != reverse_dir(w_dirEff))) begin
                        r_pending <= w_btnDir;
                    end
                    if (w_moveTick) begin
                        r_dir <= r_pending;
                        if (w_hit) begin
                            r_state    <= OVER;
                            r_gameOver <= 1'b1;
                        end else begin
                            for (int i = MAX_LEN - 1; i > 0; i--) begin
                                r_segX[i] <= r_segX[i-1];
                                r_segY[i] <= r_segY[i-1];
                            end
                            r_segX[0] <= w_nextX;
                            r_segY[0] <= w_nextY;
                            if (w_eat) begin
                                r_foodEaten <= 1'b1;
                                if (r_length != LEN_W'(MAX_LEN)) begin
                                    r_length <= r_length + LEN_W'(1);
                                end
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed scoreboard bench for snake_ctrl; expectations follow SNAKE_WRAP_EN when it is defined.
module tb_snake_ctrl;

    logic       clk = 1'b0;
    logic       resetA, resetB;
    logic       upA, downA, leftA, rightA;
    logic [9:0] foodXA, foodYA, foodXB, foodYB;
    logic [4:0] segIdxA, segIdxB;
    logic [9:0] segXA, segYA, headXA, headYA;
    logic [9:0] segXB, segYB, headXB, headYB;
    logic [5:0] lengthA, lengthB;
    logic       foodEatenA, gameOverA, foodEatenB, gameOverB;

    typedef struct {
        string       tag;
        logic [31:0] expVal;
    } exp_t;

    exp_t sbQueue[$];
    int   compareCount = 0;
    int   failCount    = 0;

    always #5 clk = ~clk;

    snake_ctrl #(.TICK_DIV(4)) dutA (
        .clk(clk), .reset(resetA),
        .btn_up(upA), .btn_down(downA), .btn_left(leftA), .btn_right(rightA),
        .food_x(foodXA), .food_y(foodYA), .seg_idx(segIdxA),
        .seg_x(segXA), .seg_y(segYA), .head_x(headXA), .head_y(headYA),
        .length(lengthA), .food_eaten(foodEatenA), .game_over(gameOverA)
    );

    snake_ctrl #(.TICK_DIV(4), .START_X(620)) dutB (
        .clk(clk), .reset(resetB),
        .btn_up(1'b0), .btn_down(1'b0), .btn_left(1'b0), .btn_right(1'b0),
        .food_x(foodXB), .food_y(foodYB), .seg_idx(segIdxB),
        .seg_x(segXB), .seg_y(segYB), .head_x(headXB), .head_y(headYB),
        .length(lengthB), .food_eaten(foodEatenB), .game_over(gameOverB)
    );

    task automatic expectVal(input string tag, input int value);
        exp_t e;
        e.tag    = tag;
        e.expVal = 32'(value);
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        compareCount++;
        if (sbQueue.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_empty: observed %0d required an expectation", observed);
        end else begin
            e = sbQueue.pop_front();
            assert (observed === e.expVal) else begin
                failCount++;
                $error("[TB] FAIL %s: observed %0d required %0d", e.tag, observed, e.expVal);
            end
        end
    endtask

    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic u, input logic d, input logic l, input logic r);
        upA    = u;
        downA  = d;
        leftA  = l;
        rightA = r;
    endtask

    task automatic checkA(input string tag, input int hx, input int hy, input int len,
                          input int fe, input int go);
        expectVal({tag, ".head_x"}, hx);
        expectVal({tag, ".head_y"}, hy);
        expectVal({tag, ".length"}, len);
        expectVal({tag, ".food_eaten"}, fe);
        expectVal({tag, ".game_over"}, go);
        checkOutput(32'(headXA));
        checkOutput(32'(headYA));
        checkOutput(32'(lengthA));
        checkOutput(32'(foodEatenA));
        checkOutput(32'(gameOverA));
    endtask

    task automatic checkSegA(input string tag, input int idx, input int x, input int y);
        segIdxA = 5'(idx);
        #1;
        expectVal({tag, ".seg_x"}, x);
        expectVal({tag, ".seg_y"}, y);
        checkOutput(32'(segXA));
        checkOutput(32'(segYA));
    endtask

    task automatic checkB(input string tag, input int hx, input int fe, input int go);
        expectVal({tag, ".head_x"}, hx);
        expectVal({tag, ".food_eaten"}, fe);
        expectVal({tag, ".game_over"}, go);
        checkOutput(32'(headXB));
        checkOutput(32'(foodEatenB));
        checkOutput(32'(gameOverB));
    endtask

    task automatic resetDutA();
        resetA = 1'b1;
        stepEdges(2);
        resetA = 1'b0;
    endtask

    // Grows to length 5 heading right, then turns up and left; leaves the head at (330,230).
    task automatic selfSetup(input string tag);
        resetDutA();
        foodXA = 10'd330; foodYA = 10'd240;
        stepEdges(4);
        checkA({tag, "_eat1"}, 330, 240, 4, 1, 0);
        foodXA = 10'd340;
        stepEdges(4);
        checkA({tag, "_eat2"}, 340, 240, 5, 1, 0);
        foodXA = 10'd600; foodYA = 10'd400;
        applyStimulus(1, 0, 0, 0);
        stepEdges(1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(3);
        checkA({tag, "_up"}, 340, 230, 5, 0, 0);
        applyStimulus(0, 0, 1, 0);
        stepEdges(1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(3);
        checkA({tag, "_left"}, 330, 230, 5, 0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetA = 1'b1; resetB = 1'b1;
        applyStimulus(0, 0, 0, 0);
        foodXA = 10'd600; foodYA = 10'd400;
        foodXB = 10'd0;   foodYB = 10'd0;
        segIdxA = '0; segIdxB = '0;
        stepEdges(2);

        // Right-edge start: wall (or wrap) on the second step.
        resetB = 1'b0;
        stepEdges(4);
        checkB("edge_step1", 630, 0, 0);
        stepEdges(4);
`ifdef SNAKE_WRAP_EN
        checkB("edge_step2", 0, 0, 0);
`else
        checkB("edge_step2", 630, 0, 1);
`endif
        foodXB = 10'd630; foodYB = 10'd240;
        stepEdges(4);
`ifdef SNAKE_WRAP_EN
        checkB("edge_after", 10, 0, 0);
`else
        checkB("edge_after", 630, 0, 1);
`endif
        resetB = 1'b1;

        // Reset state, first move, eating and growth.
        resetDutA();
        foodXA = 10'd340; foodYA = 10'd240;
        checkA("reset", 320, 240, 3, 0, 0);
        checkSegA("reset_seg1", 1, 310, 240);
        stepEdges(3);
        checkA("pre_move", 320, 240, 3, 0, 0);
        stepEdges(1);
        checkA("move1", 330, 240, 3, 0, 0);
        checkSegA("move1_seg2", 2, 310, 240);
        stepEdges(3);
        checkA("pre_eat", 330, 240, 3, 0, 0);
        stepEdges(1);
        checkA("eat", 340, 240, 4, 1, 0);
        checkSegA("eat_seg3", 3, 310, 240);
        foodXA = 10'd600; foodYA = 10'd400;
        stepEdges(1);
        checkA("eat_pulse_end", 340, 240, 4, 0, 0);

        // Steering: reverse ignored, turn up, priority with two buttons.
        applyStimulus(0, 0, 1, 0);
        stepEdges(3);
        applyStimulus(0, 0, 0, 0);
        checkA("reverse_ignored", 350, 240, 4, 0, 0);
        applyStimulus(1, 0, 0, 0);
        stepEdges(1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(3);
        checkA("turn_up", 350, 230, 4, 0, 0);
        applyStimulus(1, 0, 0, 1);
        stepEdges(4);
        applyStimulus(0, 0, 0, 0);
        checkA("up_over_right", 350, 220, 4, 0, 0);

        // Self-collision into the body.
        selfSetup("self");
        applyStimulus(0, 1, 0, 0);
        stepEdges(1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(3);
        checkA("self_hit", 330, 230, 5, 0, 1);
        applyStimulus(0, 0, 0, 1);
        stepEdges(4);
        applyStimulus(0, 0, 0, 0);
        checkA("self_frozen", 330, 230, 5, 0, 1);

        // Self-collision on a food cell: collision wins over eating.
        selfSetup("selffood");
        foodXA = 10'd330; foodYA = 10'd240;
        applyStimulus(0, 1, 0, 0);
        stepEdges(1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(3);
        checkA("selffood_hit", 330, 230, 5, 0, 1);

        // Reset asserted during a step cycle while game over.
        stepEdges(3);
        resetA = 1'b1;
        stepEdges(1);
        resetA = 1'b0;
        foodXA = 10'd600; foodYA = 10'd400;
        checkA("reset_in_over", 320, 240, 3, 0, 0);
        checkSegA("reset_in_over_seg1", 1, 310, 240);
        stepEdges(3);
        checkA("rst_pre_move", 320, 240, 3, 0, 0);
        stepEdges(1);
        checkA("rst_move1", 330, 240, 3, 0, 0);

        if (sbQueue.size() != 0) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL scoreboard_leftover: observed %0d entries required 0", sbQueue.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
